// File: rtl/dpc_fetch_pkg.sv
// dpc_fetch_pkg: shared types and constants for the DekatronPC fetch sequencer.
package dpc_fetch_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, LOAD, DONE} state_e;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Step lamps are one-hot in enum order, bit0 = IDLE.
    function automatic logic [3:0] step_of(state_e s);
        return 4'b0001 << s;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one decade of the BCD instruction pointer with carry/borrow chaining.
module bcd_digit_counter
    import dpc_fetch_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic       load_i,
    input  bcd_digit_t load_val_i,
    input  logic       ci_i,
    output bcd_digit_t q_o,
    output logic       co_o
);

    bcd_digit_t q_q;
    logic       at_edge;

    assign at_edge = dir_i ? (q_q == '0) : (q_q == BCD_MAX);
    assign co_o    = ci_i && at_edge;
    assign q_o     = q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni)
            q_q <= '0;
        else if (load_i)
            q_q <= (load_val_i > BCD_MAX) ? '0 : load_val_i;
        else if (en_i && ci_i)
            q_q <= at_edge ? (dir_i ? BCD_MAX : '0) : (dir_i ? q_q - 4'd1 : q_q + 4'd1);
    end

endmodule

// File: rtl/ip_fetch_sequencer.sv
// ip_fetch_sequencer: BCD instruction pointer stepping plus ROM req/ack opcode fetch.
// Optional FETCH_TIMEOUT_EN adds a LOAD watchdog with a sticky Fault flag.
module ip_fetch_sequencer
    import dpc_fetch_pkg::*;
#(
    parameter int IP_DIGITS      = 5,
    parameter int OPCODE_WIDTH   = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    Start,
    input  logic                    Reverse,
    input  logic                    IpLoad,
    input  logic [4*IP_DIGITS-1:0]  IpLoadValue,
    output logic                    RomReq,
    output logic [4*IP_DIGITS-1:0]  RomAddr,
    input  logic                    RomAck,
    input  logic [OPCODE_WIDTH-1:0] RomData,
    output logic [4*IP_DIGITS-1:0]  Ip,
    output logic [OPCODE_WIDTH-1:0] Opcode,
    output logic                    OpcodeValid,
    output logic                    Busy,
    output logic [3:0]              Step,
    output logic                    Fault
);

    state_e                  state_q;
    logic                    dir_q;
    logic                    rom_req_q;
    logic                    valid_q;
    logic [OPCODE_WIDTH-1:0] opcode_q;
    logic [4*IP_DIGITS-1:0]  ip_w;
    logic [IP_DIGITS:0]      carry;
    logic                    count_en;
    logic                    ip_load;

    assign count_en = state_q == COUNT;
    assign ip_load  = state_q == IDLE && IpLoad;
    assign carry[0] = 1'b1;

    genvar g;
    generate
        for (g = 0; g < IP_DIGITS; g++) begin : g_digit
            bcd_digit_counter u_digit (
                .clk_i      (Clk),
                .rst_ni     (Rst_n),
                .en_i       (count_en),
                .dir_i      (dir_q),
                .load_i     (ip_load),
                .load_val_i (IpLoadValue[4*g +: 4]),
                .ci_i       (carry[g]),
                .q_o        (ip_w[4*g +: 4]),
                .co_o       (carry[g+1])
            );
        end
    endgenerate

`ifdef FETCH_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_q;
    logic          fault_q;
`endif

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            dir_q     <= 1'b0;
            rom_req_q <= 1'b0;
            valid_q   <= 1'b0;
            opcode_q  <= '0;
`ifdef FETCH_TIMEOUT_EN
            to_q      <= '0;
            fault_q   <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (!IpLoad && Start) begin
                    dir_q   <= Reverse;
                    state_q <= COUNT;
                end
                COUNT: begin
                    rom_req_q <= 1'b1;
                    state_q   <= LOAD;
`ifdef FETCH_TIMEOUT_EN
                    to_q      <= '0;
`endif
                end
                LOAD: begin
                    if (RomAck) begin
                        opcode_q  <= RomData;
                        valid_q   <= 1'b1;
                        rom_req_q <= 1'b0;
                        state_q   <= DONE;
                    end
`ifdef FETCH_TIMEOUT_EN
                    // Give up after TIMEOUT_CYCLES unacknowledged LOAD cycles; Ip keeps its stepped value.
                    else if (to_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        rom_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                        state_q   <= IDLE;
                    end else
                        to_q <= to_q + 1'b1;
`endif
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Ip          = ip_w;
    assign RomAddr     = ip_w;
    assign RomReq      = rom_req_q;
    assign Opcode      = opcode_q;
    assign OpcodeValid = valid_q;
    assign Busy        = state_q != IDLE;
    assign Step        = step_of(state_q);
`ifdef FETCH_TIMEOUT_EN
    assign Fault       = fault_q;
`else
    assign Fault       = 1'b0;
`endif

endmodule

// File: tb/tb_ip_fetch_sequencer.sv
// tb_ip_fetch_sequencer: directed self-checking bench for ip_fetch_sequencer.
module tb_ip_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        reverse = 1'b0;
    logic        ip_load = 1'b0;
    logic [19:0] ip_load_value = '0;
    logic        rom_req;
    logic [19:0] rom_addr;
    logic        rom_ack = 1'b0;
    logic [15:0] rom_data = '0;
    logic [19:0] ip;
    logic [15:0] opcode;
    logic        opcode_valid;
    logic        busy;
    logic [3:0]  step;
    logic        fault;

    int vectors = 0;
    int miscompares = 0;

    int          req_cycles;
    logic        addr_stable;
    logic [19:0] addr_load;
    logic        valid_seen;

    ip_fetch_sequencer dut (
        .Clk         (clk),
        .Rst_n       (rst_n),
        .Start       (start),
        .Reverse     (reverse),
        .IpLoad      (ip_load),
        .IpLoadValue (ip_load_value),
        .RomReq      (rom_req),
        .RomAddr     (rom_addr),
        .RomAck      (rom_ack),
        .RomData     (rom_data),
        .Ip          (ip),
        .Opcode      (opcode),
        .OpcodeValid (opcode_valid),
        .Busy        (busy),
        .Step        (step),
        .Fault       (fault)
    );

    always #5 clk = ~clk;

    // Drives one fetch from IDLE; ROM acks on the k-th LOAD cycle. Returns at the negedge after DONE.
    task automatic fetch(input logic rev, input int k, input logic [15:0] data, input logic poke);
        start = 1'b1;
        reverse = rev;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        req_cycles = 0;
        addr_stable = 1'b1;
        addr_load = rom_addr;
        for (int i = 1; i < k; i++) begin
            if (rom_req) req_cycles++;
            if (rom_addr !== addr_load) addr_stable = 1'b0;
            start = poke && i[0];
            @(negedge clk);
        end
        if (rom_req) req_cycles++;
        if (rom_addr !== addr_load) addr_stable = 1'b0;
        start = 1'b0;
        rom_ack = 1'b1;
        rom_data = data;
        @(negedge clk);
        rom_ack = 1'b0;
        valid_seen = opcode_valid;
        @(negedge clk);
    endtask

    task automatic load_ip(input logic [19:0] v);
        ip_load = 1'b1;
        ip_load_value = v;
        @(negedge clk);
        ip_load = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (ip !== 20'h00000) begin miscompares++; $display("FAIL reset_ip got %h exp 00000", ip); end
        vectors++; if (step !== 4'b0001) begin miscompares++; $display("FAIL reset_step got %b exp 0001", step); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy); end
        vectors++; if (rom_req !== 1'b0) begin miscompares++; $display("FAIL reset_romreq got %b exp 0", rom_req); end
        vectors++; if (opcode !== 16'h0000) begin miscompares++; $display("FAIL reset_opcode got %h exp 0000", opcode); end
        vectors++; if (opcode_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b exp 0", opcode_valid); end
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault got %b exp 0", fault); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward;
        int n_valid;
        int pos [3];
        logic [19:0] ips [3];
        n_valid = 0;
        start = 1'b1;
        rom_ack = 1'b1;
        rom_data = 16'hA5A5;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (opcode_valid === 1'b1) begin
                if (n_valid < 3) begin
                    pos[n_valid] = i;
                    ips[n_valid] = ip;
                end
                n_valid++;
            end
        end
        start = 1'b0;
        rom_ack = 1'b0;
        vectors++; if (n_valid != 3) begin miscompares++; $display("FAIL fwd_valid_count got %0d exp 3", n_valid); end
        if (n_valid >= 3) begin
            vectors++; if (pos[0] != 3 || pos[1] != 7 || pos[2] != 11) begin miscompares++; $display("FAIL fwd_valid_cycles got %0d,%0d,%0d exp 3,7,11", pos[0], pos[1], pos[2]); end
            vectors++; if (ips[0] !== 20'h00001) begin miscompares++; $display("FAIL fwd_ip1 got %h exp 00001", ips[0]); end
            vectors++; if (ips[1] !== 20'h00002) begin miscompares++; $display("FAIL fwd_ip2 got %h exp 00002", ips[1]); end
            vectors++; if (ips[2] !== 20'h00003) begin miscompares++; $display("FAIL fwd_ip3 got %h exp 00003", ips[2]); end
        end
        vectors++; if (opcode !== 16'hA5A5) begin miscompares++; $display("FAIL fwd_opcode got %h exp a5a5", opcode); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || ip !== 20'h00003) begin miscompares++; $display("FAIL fwd_idle got busy=%b ip=%h exp busy=0 ip=00003", busy, ip); end
    endtask

    task automatic test_wrap;
        start = 1'b1;
        load_ip(20'h99999);
        start = 1'b0;
        vectors++; if (ip !== 20'h99999) begin miscompares++; $display("FAIL wrap_load got %h exp 99999", ip); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL wrap_load_priority got busy=%b exp 0", busy); end
        fetch(1'b0, 1, 16'h1234, 1'b0);
        vectors++; if (addr_load !== 20'h00000) begin miscompares++; $display("FAIL wrap_fwd_addr got %h exp 00000", addr_load); end
        vectors++; if (ip !== 20'h00000) begin miscompares++; $display("FAIL wrap_fwd_ip got %h exp 00000", ip); end
        vectors++; if (opcode !== 16'h1234 || valid_seen !== 1'b1) begin miscompares++; $display("FAIL wrap_fwd_opcode got %h/%b exp 1234/1", opcode, valid_seen); end
        fetch(1'b1, 1, 16'h4321, 1'b0);
        vectors++; if (ip !== 20'h99999) begin miscompares++; $display("FAIL wrap_rev_ip got %h exp 99999", ip); end
    endtask

    task automatic test_carry;
        load_ip(20'h00019);
        fetch(1'b0, 1, 16'h0001, 1'b0);
        vectors++; if (ip !== 20'h00020) begin miscompares++; $display("FAIL carry_ip got %h exp 00020", ip); end
        load_ip(20'h00100);
        fetch(1'b1, 1, 16'h0002, 1'b0);
        vectors++; if (ip !== 20'h00099) begin miscompares++; $display("FAIL borrow_ip got %h exp 00099", ip); end
        load_ip(20'h1C345);
        vectors++; if (ip !== 20'h10345) begin miscompares++; $display("FAIL bad_digit_load got %h exp 10345", ip); end
        load_ip(20'hF9A08);
        vectors++; if (ip !== 20'h09008) begin miscompares++; $display("FAIL bad_digit_load2 got %h exp 09008", ip); end
    endtask

    task automatic test_delayed_ack;
        load_ip(20'h00042);
        fetch(1'b0, 5, 16'hBEEF, 1'b1);
        vectors++; if (req_cycles != 5) begin miscompares++; $display("FAIL delay_req_cycles got %0d exp 5", req_cycles); end
        vectors++; if (addr_stable !== 1'b1 || addr_load !== 20'h00043) begin miscompares++; $display("FAIL delay_addr got %h stable=%b exp 00043 stable=1", addr_load, addr_stable); end
        vectors++; if (opcode !== 16'hBEEF || valid_seen !== 1'b1) begin miscompares++; $display("FAIL delay_opcode got %h/%b exp beef/1", opcode, valid_seen); end
        vectors++; if (rom_req !== 1'b0) begin miscompares++; $display("FAIL delay_req_drop got %b exp 0", rom_req); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0 || ip !== 20'h00043) begin miscompares++; $display("FAIL delay_no_queue got busy=%b ip=%h exp busy=0 ip=00043", busy, ip); end
    endtask

    task automatic test_reset_mid_load;
        load_ip(20'h00007);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        vectors++; if (rom_req !== 1'b1 || ip !== 20'h00008 || step !== 4'b0100) begin miscompares++; $display("FAIL midload_pre got req=%b ip=%h step=%b exp 1/00008/0100", rom_req, ip, step); end
        rst_n = 1'b0;
        @(negedge clk);
        vectors++; if (rom_req !== 1'b0) begin miscompares++; $display("FAIL midload_req got %b exp 0", rom_req); end
        vectors++; if (ip !== 20'h00000) begin miscompares++; $display("FAIL midload_ip got %h exp 00000", ip); end
        vectors++; if (step !== 4'b0001) begin miscompares++; $display("FAIL midload_step got %b exp 0001", step); end
        vectors++; if (opcode !== 16'h0000) begin miscompares++; $display("FAIL midload_opcode got %h exp 0000", opcode); end
        rst_n = 1'b1;
        rom_ack = 1'b1;
        rom_data = 16'hFFFF;
        repeat (2) @(negedge clk);
        rom_ack = 1'b0;
        vectors++; if (opcode !== 16'h0000 || opcode_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL late_ack got opc=%h v=%b busy=%b exp 0000/0/0", opcode, opcode_valid, busy); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout;
        int n_req;
        logic v;
        n_req = 0;
        v = 1'b0;
        load_ip(20'h00500);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rom_req === 1'b1) n_req++;
            if (opcode_valid === 1'b1) v = 1'b1;
        end
        vectors++; if (n_req != 15) begin miscompares++; $display("FAIL timeout_req_cycles got %0d exp 15", n_req); end
        vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL timeout_fault got %b exp 1", fault); end
        vectors++; if (v !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL timeout_valid got v=%b busy=%b exp 0/0", v, busy); end
        vectors++; if (ip !== 20'h00501) begin miscompares++; $display("FAIL timeout_ip got %h exp 00501", ip); end
        fetch(1'b0, 1, 16'h5A5A, 1'b0);
        vectors++; if (opcode !== 16'h5A5A || valid_seen !== 1'b1 || fault !== 1'b1) begin miscompares++; $display("FAIL timeout_recover got %h/%b/%b exp 5a5a/1/1", opcode, valid_seen, fault); end
    endtask
`endif

    initial begin
        test_reset;
        test_forward;
        test_wrap;
        test_carry;
        test_delayed_ack;
        test_reset_mid_load;
`ifdef FETCH_TIMEOUT_EN
        test_reset;
        test_timeout;
`else
        vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL fault_tied got %b exp 0", fault); end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
